// File: rtl/pwm_multi_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi_unit
//  Purpose  : Multi-channel PWM generator. One shared prescaler and period
//             counter drive NUM_CH compare channels, each with its own duty,
//             enable and polarity. Period, duty, enable, polarity (and mode)
//             are held in shadow registers that only change at a period
//             boundary, so reprogramming never produces a runt pulse.
//  Options  : PWM_CENTER_ALIGN_EN - when defined, adds up/down
//             (center-aligned) counting selected by pwm_center. When it is
//             not defined, pwm_center is ignored and only edge-aligned
//             counting exists.
//  Ports    : pwm_clk, pwm_reset (sync, active high), pwm_en (run enable)
//             pwm_range    - period top value
//             pwm_prescale - counter advances every pwm_prescale+1 clocks
//             pwm_value    - packed duties, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//             pwm_ch_en    - per-channel output enable
//             pwm_polarity - per-channel invert and inactive level
//             pwm_center   - center-aligned mode select
//             pwm_load     - request shadow update at next period boundary
//             pwm_out      - registered PWM outputs
//             pwm_period   - one-cycle pulse after each period boundary
//             pwm_load_ack - one-cycle pulse when shadows are updated
//             pwm_count    - current counter value
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_unit #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                        pwm_clk,
  input  logic                        pwm_reset,
  input  logic                        pwm_en,
  input  logic [CNT_WIDTH-1:0]        pwm_range,
  input  logic [PRESC_WIDTH-1:0]      pwm_prescale,
  input  logic [NUM_CH*CNT_WIDTH-1:0] pwm_value,
  input  logic [NUM_CH-1:0]           pwm_ch_en,
  input  logic [NUM_CH-1:0]           pwm_polarity,
  input  logic                        pwm_center,
  input  logic                        pwm_load,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic                        pwm_period,
  output logic                        pwm_load_ack,
  output logic [CNT_WIDTH-1:0]        pwm_count
);

  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO  = '0;
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

  logic [PRESC_WIDTH-1:0]      presc_cnt;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [CNT_WIDTH-1:0]        cnt_next;
  logic                        load_pending;
  logic [CNT_WIDTH-1:0]        range_s;
  logic [NUM_CH*CNT_WIDTH-1:0] value_s;
  logic [NUM_CH-1:0]           ch_en_s;
  logic [NUM_CH-1:0]           pol_s;
  logic [NUM_CH-1:0]           out_bits;
  logic [NUM_CH-1:0]           out_next;
  logic                        period_pulse;
  logic                        ack_pulse;
  logic                        tick;
  logic                        boundary;
  logic                        do_load;

  // >= rather than == so that lowering pwm_prescale below the running
  // prescaler value ticks at once instead of wrapping the whole range.
  assign tick    = (presc_cnt >= pwm_prescale);
  assign do_load = boundary && (load_pending || pwm_load);

`ifdef PWM_CENTER_ALIGN_EN
  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  logic [0:0] dir_state;
  logic [0:0] dir_next;
  logic       center_s;

  // Direction state register.
  always_ff @(posedge pwm_clk) begin
    if (pwm_reset || !pwm_en) begin
      dir_state <= DIR_UP;
    end else if (tick) begin
      dir_state <= dir_next;
    end
  end

  // Next count / direction and boundary detect; applied only on tick.
  always_comb begin
    boundary = 1'b0;
    cnt_next = cnt;
    dir_next = dir_state;
    if (center_s) begin
      if (range_s == CNT_ZERO) begin
        // Degenerate range: counter parks at 0 and every tick ends a period.
        boundary = tick;
        cnt_next = CNT_ZERO;
        dir_next = DIR_UP;
      end else if (dir_state == DIR_UP) begin
        if (cnt >= range_s) begin
          cnt_next = cnt - CNT_ONE;
          dir_next = DIR_DOWN;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end else begin
        if (cnt == CNT_ZERO) begin
          // Bottom of the down slope: 0 is visited once per period.
          boundary = tick;
          cnt_next = CNT_ONE;
          dir_next = DIR_UP;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
    end else begin
      dir_next = DIR_UP;
      if (cnt == range_s) begin
        boundary = tick;
        cnt_next = CNT_ZERO;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge pwm_clk) begin
    if (pwm_reset) begin
      center_s <= 1'b0;
    end else if (!pwm_en || do_load) begin
      center_s <= pwm_center;
    end
  end
`else
  logic unused_center;
  assign unused_center = pwm_center;

  always_comb begin
    boundary = 1'b0;
    cnt_next = cnt + CNT_ONE;
    if (cnt == range_s) begin
      boundary = tick;
      cnt_next = CNT_ZERO;
    end
  end
`endif

  // Per-channel compare against the live counter and current shadows.
  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic raw;
      assign raw          = (cnt < value_s[ch*CNT_WIDTH +: CNT_WIDTH]);
      assign out_next[ch] = ch_en_s[ch] ? (raw ^ pol_s[ch]) : pol_s[ch];
    end
  endgenerate

  always_ff @(posedge pwm_clk) begin
    if (pwm_reset) begin
      presc_cnt    <= '0;
      cnt          <= '0;
      load_pending <= 1'b0;
      range_s      <= '0;
      value_s      <= '0;
      ch_en_s      <= '0;
      pol_s        <= '0;
      out_bits     <= '0;
      period_pulse <= 1'b0;
      ack_pulse    <= 1'b0;
    end else if (!pwm_en) begin
      // Stopped: shadows track the inputs so a restart uses fresh settings.
      presc_cnt    <= '0;
      cnt          <= '0;
      load_pending <= 1'b0;
      range_s      <= pwm_range;
      value_s      <= pwm_value;
      ch_en_s      <= pwm_ch_en;
      pol_s        <= pwm_polarity;
      out_bits     <= pol_s;
      period_pulse <= 1'b0;
      ack_pulse    <= 1'b0;
    end else begin
      presc_cnt    <= tick ? '0 : presc_cnt + PRESC_ONE;
      if (tick) begin
        cnt <= cnt_next;
      end
      out_bits     <= out_next;
      period_pulse <= boundary;
      ack_pulse    <= do_load;
      if (do_load) begin
        range_s      <= pwm_range;
        value_s      <= pwm_value;
        ch_en_s      <= pwm_ch_en;
        pol_s        <= pwm_polarity;
        load_pending <= 1'b0;
      end else if (pwm_load) begin
        load_pending <= 1'b1;
      end
    end
  end

  assign pwm_out      = out_bits;
  assign pwm_period   = period_pulse;
  assign pwm_load_ack = ack_pulse;
  assign pwm_count    = cnt;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_multi_unit
//  Purpose  : Self-checking bench for pwm_multi_unit (NUM_CH=4). Steady-state
//             period and per-channel high times are checked from a vector
//             table; reset, shadow load, enable drop and counting mode are
//             checked with directed sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_unit;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int PW  = 8;

  logic              pwm_clk = 1'b0;
  logic              pwm_reset;
  logic              pwm_en;
  logic [CW-1:0]     pwm_range;
  logic [PW-1:0]     pwm_prescale;
  logic [NCH*CW-1:0] pwm_value;
  logic [NCH-1:0]    pwm_ch_en;
  logic [NCH-1:0]    pwm_polarity;
  logic              pwm_center;
  logic              pwm_load;
  logic [NCH-1:0]    pwm_out;
  logic              pwm_period;
  logic              pwm_load_ack;
  logic [CW-1:0]     pwm_count;

  always #5 pwm_clk = ~pwm_clk;

  pwm_multi_unit #(
    .NUM_CH      (NCH),
    .CNT_WIDTH   (CW),
    .PRESC_WIDTH (PW)
  ) dut (
    .pwm_clk      (pwm_clk),
    .pwm_reset    (pwm_reset),
    .pwm_en       (pwm_en),
    .pwm_range    (pwm_range),
    .pwm_prescale (pwm_prescale),
    .pwm_value    (pwm_value),
    .pwm_ch_en    (pwm_ch_en),
    .pwm_polarity (pwm_polarity),
    .pwm_center   (pwm_center),
    .pwm_load     (pwm_load),
    .pwm_out      (pwm_out),
    .pwm_period   (pwm_period),
    .pwm_load_ack (pwm_load_ack),
    .pwm_count    (pwm_count)
  );

  typedef struct {
    logic [CW-1:0]     rng;
    logic [PW-1:0]     presc;
    logic [NCH*CW-1:0] values;
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    pol;
    int                period;
    int                h0, h1, h2, h3;
  } vec_t;

  vec_t tbl [5];
  int   errors = 0;
  int   checks = 0;
  int   len;
  int   hi [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bounded wait for the next pwm_period pulse (sampled at negedge).
  task automatic wait_pulse(input string name);
    int n = 0;
    while (!pwm_period && n < 2000) begin
      @(negedge pwm_clk);
      n++;
    end
    check(name, int'(pwm_period), 1);
  endtask

  // Starting on a pwm_period cycle, accumulate high clocks per channel up to
  // the next pwm_period cycle. pwm_load is pulsed on cycle load_at (if >0).
  task automatic measure(input int load_at);
    len = 0;
    for (int c = 0; c < NCH; c++) hi[c] = 0;
    do begin
      for (int c = 0; c < NCH; c++) hi[c] += int'(pwm_out[c]);
      len++;
      pwm_load = (len == load_at);
      @(negedge pwm_clk);
    end while (!pwm_period && len < 2000);
    pwm_load = 1'b0;
  endtask

  // Program inputs while stopped (shadows follow), start, and align to the
  // first period boundary.
  task automatic configure(input logic [CW-1:0] r, input logic [PW-1:0] p,
                           input logic [NCH*CW-1:0] v, input logic [NCH-1:0] ce,
                           input logic [NCH-1:0] pol, input logic c);
    @(negedge pwm_clk);
    pwm_en       = 1'b0;
    pwm_range    = r;
    pwm_prescale = p;
    pwm_value    = v;
    pwm_ch_en    = ce;
    pwm_polarity = pol;
    pwm_center   = c;
    pwm_load     = 1'b0;
    repeat (3) @(negedge pwm_clk);
    pwm_en = 1'b1;
    @(negedge pwm_clk);
    wait_pulse("sync_first_boundary");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_h [4];
    int seq [8];

    tbl[0] = '{16'd9, 8'd0, {16'd12, 16'd10, 16'd3, 16'd0}, 4'b1111, 4'b0000, 10, 0, 3, 10, 10};
    tbl[1] = '{16'd3, 8'd2, {16'd0, 16'd0, 16'd0, 16'd2}, 4'b0001, 4'b0011, 12, 6, 12, 0, 0};
    tbl[2] = '{16'd4, 8'd1, {16'd2, 16'd0, 16'd5, 16'd1}, 4'b1111, 4'b0100, 10, 2, 10, 10, 4};
    tbl[3] = '{16'd0, 8'd0, {16'd0, 16'd5, 16'd1, 16'd0}, 4'b1111, 4'b0000, 1, 0, 1, 1, 0};
    tbl[4] = '{16'd2, 8'd3, {16'hFFFF, 16'd3, 16'd2, 16'd1}, 4'b1011, 4'b1000, 12, 4, 8, 0, 0};

    // ---------------- reset with pwm_en high ----------------
    pwm_reset    = 1'b1;
    pwm_en       = 1'b1;
    pwm_range    = '0;
    pwm_prescale = '0;
    pwm_value    = '0;
    pwm_ch_en    = '0;
    pwm_polarity = '0;
    pwm_center   = 1'b0;
    pwm_load     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pwm_clk);
      check($sformatf("reset_out_%0d", k), int'(pwm_out), 0);
      check($sformatf("reset_count_%0d", k), int'(pwm_count), 0);
      check($sformatf("reset_period_%0d", k), int'(pwm_period), 0);
      check($sformatf("reset_ack_%0d", k), int'(pwm_load_ack), 0);
    end
    pwm_reset = 1'b0;
    // Shadows are zero: range 0 means every tick is a boundary at count 0.
    for (int k = 0; k < 2; k++) begin
      @(negedge pwm_clk);
      check($sformatf("post_reset_count_%0d", k), int'(pwm_count), 0);
      check($sformatf("post_reset_period_%0d", k), int'(pwm_period), 1);
      check($sformatf("post_reset_out_%0d", k), int'(pwm_out), 0);
    end

    // ---------------- table-driven steady-state vectors ----------------
    for (int i = 0; i < 5; i++) begin
      configure(tbl[i].rng, tbl[i].presc, tbl[i].values, tbl[i].ch_en, tbl[i].pol, 1'b0);
      measure(-1);
      exp_h[0] = tbl[i].h0;
      exp_h[1] = tbl[i].h1;
      exp_h[2] = tbl[i].h2;
      exp_h[3] = tbl[i].h3;
      check($sformatf("vec%0d_period", i), len, tbl[i].period);
      for (int c = 0; c < NCH; c++)
        check($sformatf("vec%0d_high_ch%0d", i, c), hi[c], exp_h[c]);
    end

    // ---------------- shadow load mid-period ----------------
    configure(16'd9, 8'd0, {16'd0, 16'd0, 16'd0, 16'd3}, 4'b0001, 4'b0000, 1'b0);
    pwm_value = {16'd0, 16'd0, 16'd0, 16'd7};
    pwm_range = 16'd4;
    measure(5);
    check("load_old_period", len, 10);
    check("load_old_high", hi[0], 3);
    check("load_ack_with_period", int'(pwm_load_ack), 1);
    measure(-1);
    check("load_transition_period", len, 5);
    check("load_ack_single", int'(pwm_load_ack), 0);
    measure(-1);
    check("load_new_period", len, 5);
    check("load_new_high", hi[0], 5);

    // ---------------- enable drop with pending load ----------------
    configure(16'd9, 8'd0, {16'd0, 16'd0, 16'd0, 16'd8}, 4'b0011, 4'b0010, 1'b0);
    repeat (3) @(negedge pwm_clk);
    pwm_load = 1'b1;
    @(negedge pwm_clk);
    pwm_load = 1'b0;
    @(negedge pwm_clk);
    check("drop_count_before", int'(pwm_count), 5);
    check("drop_out_before", int'(pwm_out), 4'b0011);
    pwm_en = 1'b0;
    @(negedge pwm_clk);
    check("drop_count", int'(pwm_count), 0);
    check("drop_out_polarity", int'(pwm_out), 4'b0010);
    check("drop_period", int'(pwm_period), 0);
    @(negedge pwm_clk);
    check("drop_count_held", int'(pwm_count), 0);
    pwm_en = 1'b1;
    @(negedge pwm_clk);
    check("reenable_count", int'(pwm_count), 1);
    wait_pulse("reenable_boundary");
    check("reenable_no_stale_ack", int'(pwm_load_ack), 0);

    // ---------------- counting mode ----------------
`ifdef PWM_CENTER_ALIGN_EN
    configure(16'd4, 8'd0, {16'd0, 16'd0, 16'd0, 16'd2}, 4'b0001, 4'b0000, 1'b1);
    seq = '{1, 2, 3, 4, 3, 2, 1, 0};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("center_count_%0d", k), int'(pwm_count), seq[k]);
      @(negedge pwm_clk);
    end
    check("center_period_pulse", int'(pwm_period), 1);
    measure(-1);
    check("center_period", len, 8);
    check("center_high", hi[0], 3);
`else
    // pwm_center is ignored: edge counting continues.
    configure(16'd4, 8'd0, {16'd0, 16'd0, 16'd0, 16'd2}, 4'b0001, 4'b0000, 1'b1);
    seq = '{0, 1, 2, 3, 4, 0, 1, 2};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("edge_count_%0d", k), int'(pwm_count), seq[k]);
      @(negedge pwm_clk);
    end
    wait_pulse("edge_sync");
    measure(-1);
    check("edge_only_period", len, 5);
    check("edge_only_high", hi[0], 2);
`endif

    // ---------------- reset mid-period ----------------
    configure(16'd9, 8'd0, {16'd0, 16'd0, 16'd0, 16'd5}, 4'b0001, 4'b0010, 1'b0);
    repeat (3) @(negedge pwm_clk);
    check("midreset_out_before", int'(pwm_out), 4'b0011);
    pwm_reset = 1'b1;
    @(negedge pwm_clk);
    check("midreset_count", int'(pwm_count), 0);
    check("midreset_out", int'(pwm_out), 0);
    check("midreset_period", int'(pwm_period), 0);
    pwm_reset = 1'b0;
    @(negedge pwm_clk);
    check("midreset_release_out", int'(pwm_out), 0);
    check("midreset_release_count", int'(pwm_count), 0);
    check("midreset_release_period", int'(pwm_period), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
